fmap_streamer: RTL and testbench
================================

FMAP_STREAMER -- requirements
Module: fmap_streamer

Interface
REQ-001 Parameter N, default 16: bits per channel sample (signed fixed point, opaque to this block).
REQ-002 Parameter CHANNEL, default 3: channels per pixel beat.
REQ-003 Parameter SIZE, default 6: feature-map side; frame = SIZE*SIZE pixels, raster order.
REQ-004 Parameter GAP, default 0: idle cycles inserted between consecutive beats (0..15).
REQ-005 Derived AW = max(1, clog2(SIZE*SIZE)): address width.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 wr_en  input  1  pixel write strobe into frame buffer.
REQ-009 wr_addr  input  AW  pixel index for write.
REQ-010 wr_data  input  CHANNEL*N  pixel data, channel 0 in LSBs.
REQ-011 start  input  1  single-cycle request to stream one frame.
REQ-012 busy  output  1  frame streaming in progress.
REQ-013 done  output  1  one-cycle pulse after the last beat.
REQ-014 dout_vld  output  1  beat valid; drives a conv pipeline input_vld.
REQ-015 dout  output  CHANNEL*N  beat data; drives a conv pipeline input_din.
REQ-016 dout_end  output  1  high with the final beat of the frame only.

Function
REQ-017 Frame buffer SHALL hold SIZE*SIZE words of CHANNEL*N bits; contents are not cleared by reset.
REQ-018 wr_en with wr_addr < SIZE*SIZE and busy low SHALL write wr_data at the next edge.
REQ-019 wr_en with wr_addr >= SIZE*SIZE, or while busy high, SHALL be dropped with no side effect.
REQ-020 FSM states: IDLE, READ, GAP, FIN.
REQ-021 IDLE: start high -> READ, pixel index cleared to 0, busy high from the next cycle.
REQ-022 READ: issue a synchronous read of the current index; the registered word appears on dout with dout_vld high exactly one cycle later.
REQ-023 After each READ, the FSM SHALL go to GAP if GAP > 0 (stay GAP cycles), else remain in READ with index+1.
REQ-024 First dout_vld SHALL occur 2 cycles after the edge that samples start; successive beats are spaced GAP+1 cycles apart.
REQ-025 Exactly SIZE*SIZE beats per frame, indices 0..SIZE*SIZE-1 ascending; no beat repeated or skipped.
REQ-026 dout_end SHALL be high only on the beat of index SIZE*SIZE-1 and coincide with its dout_vld.
REQ-027 After the last read issue -> FIN; done SHALL pulse the cycle after the dout_end beat; busy drops in the same cycle done is high; FSM returns to IDLE.
REQ-028 dout SHALL be all-zero whenever dout_vld is low; dout_end is never high without dout_vld.
REQ-029 start while busy high (including the done cycle) SHALL be ignored.
REQ-030 start in the cycle after done SHALL be accepted normally (back-to-back frames).
REQ-031 Total frame length start-edge to done = 2 + (SIZE*SIZE-1)*(GAP+1) + 1 cycles.
REQ-032 No backpressure exists; downstream SHALL accept every beat.

Reset
REQ-033 rst high SHALL asynchronously force busy, done, dout_vld, dout_end to 0, dout to 0, FSM to IDLE, index to 0.
REQ-034 rst mid-frame SHALL abort the frame with no dout_end or done; a start after rst release streams from index 0.
REQ-035 Frame buffer writes and reads SHALL be inhibited while rst is high.

Verification
REQ-036 SIZE=6, GAP=0: write pixel k = k in every channel, pulse start at cycle 10 -> dout_vld cycles 12..47 carrying 0..35, dout_end at cycle 47, done at 48.
REQ-037 GAP=2: same frame -> beats every 3 cycles, 36 beats, dout_vld never high on two consecutive cycles.
REQ-038 Write to wr_addr 36 with data 0xFFFF, and write to index 5 while busy -> frame still reads original values; index 5 unchanged.
REQ-039 start pulsed at the 3rd beat and on the done cycle -> ignored; start the cycle after done -> second frame identical to first.
REQ-040 rst asserted at beat 20 for 1 cycle -> all outputs 0 immediately, no done; new start -> full 36-beat frame from index 0 with buffer data intact.
REQ-041 CHANNEL=3, N=16: write {16'h0003,16'h0002,16'h0001} at index 0 -> first beat dout = 48'h000300020001.

Source files
------------

// File: rtl/fmap_streamer.sv
// fmap_streamer
//   Holds one SIZE x SIZE feature map, one CHANNEL*N-bit word per pixel.
//   On a start request it streams every pixel in raster order as a beat
//   for a convolution pipeline input. GAP idle cycles are inserted between
//   consecutive beats.
//
// Ports
//   clk, rst  : single rising-edge clock; asynchronous active-high reset
//   wr_en     : pixel write strobe (dropped while busy, during reset or
//               when wr_addr is out of range)
//   wr_addr   : pixel index to write
//   wr_data   : pixel word, channel 0 in the LSBs
//   start     : single-cycle request to stream one frame
//   busy      : a frame is being streamed
//   done      : one-cycle pulse in the cycle after the final beat
//   dout_vld  : beat valid
//   dout      : beat data, all-zero when dout_vld is low
//   dout_end  : marks the final beat of the frame
module fmap_streamer #(
  parameter int N       = 16,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 6,
  parameter int GAP     = 0,
  localparam int AW     = ($clog2(SIZE*SIZE) < 1) ? 1 : $clog2(SIZE*SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [CHANNEL*N-1:0] wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 dout_vld,
  output logic [CHANNEL*N-1:0] dout,
  output logic                 dout_end
);

  localparam int              DEPTH    = SIZE*SIZE;
  localparam int              W        = CHANNEL*N;
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH-1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP > 0) ? GAP-1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [3:0]    gap_cnt_q;
  logic          rd_en;
  logic          accept;
  logic          last_rd;
  logic          wr_ok;

  // Frame buffer: deliberately without reset so pixel data survives rst.
  logic [W-1:0]  mem [DEPTH];

  assign busy    = (state_q != S_IDLE);
  assign last_rd = (idx_q == LAST_IDX);
  assign wr_ok   = wr_en && !busy && !rst && ({1'b0, wr_addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done is high in the first IDLE cycle; a start there belongs to
        // the frame just finished and is ignored.
        if (start && !done) begin
          accept  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_en = 1'b1;
        if (last_rd) begin
          state_d = S_FIN;
        end else if (GAP > 0) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_READ;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      dout_vld  <= 1'b0;
      dout_end  <= 1'b0;
      dout      <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;

      // Index advances as each read issues, so GAP cycles just hold it.
      if (accept) begin
        idx_q <= '0;
      end else if (rd_en && !last_rd) begin
        idx_q <= idx_q + 1'b1;
      end

      if (state_q == S_GAP) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end else begin
        gap_cnt_q <= '0;
      end

      dout_vld <= rd_en;
      dout_end <= rd_en && last_rd;
      dout     <= rd_en ? mem[idx_q] : '0;
      done     <= (state_q == S_FIN);
    end
  end

endmodule

// File: tb/tb_fmap_streamer.sv
module tb_fmap_streamer;

  localparam int N    = 16;
  localparam int CH   = 3;
  localparam int SIZE = 6;
  localparam int TOT  = SIZE*SIZE;
  localparam int AW   = 6;
  localparam int W    = CH*N;

  typedef struct packed {
    logic [W-1:0] d;
    int           c;
    logic         e;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          start [2] = '{1'b0, 1'b0};
  logic          busy [2];
  logic          done [2];
  logic          vld [2];
  logic          dend [2];
  logic [W-1:0]  dout [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference frame buffer, updated only by writes the rules allow.
  logic [W-1:0] ref_mem [TOT];

  beat_t bq [2][$];
  int    dq [2][$];
  int    idle_bad [2] = '{0, 0};
  int    busy_bad [2] = '{0, 0};
  int    consec [2]   = '{0, 0};
  logic  pv [2]       = '{1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmap_streamer #(.N(N), .CHANNEL(CH), .SIZE(SIZE), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start[0]), .busy(busy[0]), .done(done[0]), .dout_vld(vld[0]),
    .dout(dout[0]), .dout_end(dend[0])
  );

  fmap_streamer #(.N(N), .CHANNEL(CH), .SIZE(SIZE), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start[1]), .busy(busy[1]), .done(done[1]), .dout_vld(vld[1]),
    .dout(dout[1]), .dout_end(dend[1])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (vld[i] === 1'b1) bq[i].push_back({dout[i], cyc, dend[i]});
      else if (dout[i] !== '0 || dend[i] !== 1'b0) idle_bad[i]++;
      if (done[i] === 1'b1) begin
        dq[i].push_back(cyc);
        if (busy[i] !== 1'b0) busy_bad[i]++;
      end
      if (vld[i] === 1'b1 && pv[i] === 1'b1) consec[i]++;
      pv[i] = vld[i];
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of run, expected completion");
    $fatal(1);
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Beat k of a frame whose start was high in cycle t0.
  function automatic beat_t exp_beat(input int k, input int g, input int t0);
    return {ref_mem[k], t0 + 2 + k*(g+1), (k == TOT-1)};
  endfunction

  function automatic int exp_done(input int g, input int t0);
    return t0 + 2 + (TOT-1)*(g+1) + 1;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      bq[i].delete();
      dq[i].delete();
    end
  endtask

  task automatic do_write(input int addr, input logic [W-1:0] data, input bit in_frame);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    if (addr < TOT && !in_frame) ref_mem[addr] = data;
  endtask

  task automatic wait_done(input int i, input int n, input int budget, output bit ok);
    int b = 0;
    while (dq[i].size() < n && b < budget) begin
      tick();
      b++;
    end
    ok = (dq[i].size() >= n);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy[i], done[i], vld[i], dend[i]} !== 4'b0 || dout[i] !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got busy=%b done=%b vld=%b end=%b dout=%h, expected all 0",
                 i, busy[i], done[i], vld[i], dend[i], dout[i]);
      end
    end
    rst = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || vld[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle dut%0d: got busy=%b vld=%b, expected 0 0", i, busy[i], vld[i]);
      end
    end
  endtask

  task automatic test_known_frame();
    int t0;
    bit ok;
    beat_t e;
    for (int k = 0; k < TOT; k++)
      do_write(k, (k == 0) ? 48'h000300020001 : {3{16'(k)}}, 1'b0);
    clear_mon();
    start[0] = 1'b1; start[1] = 1'b1; t0 = cyc;
    tick();
    start[0] = 1'b0; start[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_done(i, 1, 400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL known_done_timeout dut%0d: got %0d done pulses, expected 1", i, dq[i].size()); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bq[i].size() != TOT) begin errors++; $display("FAIL known_count dut%0d: got %0d beats, expected %0d", i, bq[i].size(), TOT); end
      for (int k = 0; k < TOT && k < bq[i].size(); k++) begin
        e = exp_beat(k, gap_of(i), t0);
        checks++;
        if (bq[i][k] !== e) begin
          errors++;
          $display("FAIL known_beat dut%0d k=%0d: got d=%h cyc=%0d end=%b, expected d=%h cyc=%0d end=%b",
                   i, k, bq[i][k].d, bq[i][k].c, bq[i][k].e, e.d, e.c, e.e);
        end
      end
      checks++;
      if (dq[i].size() != 1 || dq[i][0] != exp_done(gap_of(i), t0)) begin
        errors++;
        $display("FAIL known_done dut%0d: got %0d pulses first at %0d, expected 1 at %0d",
                 i, dq[i].size(), (dq[i].size() > 0) ? dq[i][0] : -1, exp_done(gap_of(i), t0));
      end
    end
  endtask

  task automatic test_random_frame();
    int t0;
    bit ok;
    beat_t e;
    for (int k = 0; k < TOT; k++) do_write(k, rnd_word(), 1'b0);
    clear_mon();
    start[0] = 1'b1; start[1] = 1'b1; t0 = cyc;
    tick();
    start[0] = 1'b0; start[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_done(i, 1, 400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL random_done_timeout dut%0d: got %0d done pulses, expected 1", i, dq[i].size()); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bq[i].size() != TOT) begin errors++; $display("FAIL random_count dut%0d: got %0d beats, expected %0d", i, bq[i].size(), TOT); end
      for (int k = 0; k < TOT && k < bq[i].size(); k++) begin
        e = exp_beat(k, gap_of(i), t0);
        checks++;
        if (bq[i][k] !== e) begin
          errors++;
          $display("FAIL random_beat dut%0d k=%0d: got d=%h cyc=%0d end=%b, expected d=%h cyc=%0d end=%b",
                   i, k, bq[i][k].d, bq[i][k].c, bq[i][k].e, e.d, e.c, e.e);
        end
      end
    end
  endtask

  task automatic test_dropped_writes();
    int t0;
    bit ok;
    beat_t e;
    do_write(36, 48'hFFFF, 1'b0);
    for (int j = 0; j < 6; j++) do_write($urandom_range(TOT, 63), rnd_word(), 1'b0);
    clear_mon();
    start[0] = 1'b1; start[1] = 1'b1; t0 = cyc;
    tick();
    start[0] = 1'b0; start[1] = 1'b0;
    do_write(5, ~ref_mem[5], 1'b1);
    do_write(30, ~ref_mem[30], 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_done(i, 1, 400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL drop_done_timeout dut%0d: got %0d done pulses, expected 1", i, dq[i].size()); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bq[i].size() != TOT) begin errors++; $display("FAIL drop_count dut%0d: got %0d beats, expected %0d", i, bq[i].size(), TOT); end
      for (int k = 0; k < TOT && k < bq[i].size(); k++) begin
        e = exp_beat(k, gap_of(i), t0);
        checks++;
        if (bq[i][k] !== e) begin
          errors++;
          $display("FAIL drop_beat dut%0d k=%0d: got d=%h cyc=%0d end=%b, expected d=%h cyc=%0d end=%b",
                   i, k, bq[i][k].d, bq[i][k].c, bq[i][k].e, e.d, e.c, e.e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, td, g;
    bit ok;
    beat_t e;
    for (int i = 0; i < 2; i++) begin
      g = gap_of(i);
      clear_mon();
      start[i] = 1'b1; t0 = cyc;
      tick();
      start[i] = 1'b0;
      // Pulse while the third beat is on the bus.
      wait_cyc(t0 + 2 + 2*(g+1));
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
      // Hold start across the done cycle and the cycle after it.
      td = exp_done(g, t0);
      wait_cyc(td);
      start[i] = 1'b1;
      tick();
      tick();
      start[i] = 1'b0;
      t1 = td + 1;
      wait_done(i, 2, 400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_done_timeout dut%0d: got %0d done pulses, expected 2", i, dq[i].size()); end
      checks++;
      if (bq[i].size() != 2*TOT) begin errors++; $display("FAIL b2b_count dut%0d: got %0d beats, expected %0d", i, bq[i].size(), 2*TOT); end
      for (int k = 0; k < 2*TOT && k < bq[i].size(); k++) begin
        e = (k < TOT) ? exp_beat(k, g, t0) : exp_beat(k - TOT, g, t1);
        checks++;
        if (bq[i][k] !== e) begin
          errors++;
          $display("FAIL b2b_beat dut%0d k=%0d: got d=%h cyc=%0d end=%b, expected d=%h cyc=%0d end=%b",
                   i, k, bq[i][k].d, bq[i][k].c, bq[i][k].e, e.d, e.c, e.e);
        end
      end
      checks++;
      if (dq[i].size() != 2 || dq[i][0] != td || dq[i][1] != exp_done(g, t1)) begin
        errors++;
        $display("FAIL b2b_done dut%0d: got %0d pulses, expected 2 at %0d and %0d", i, dq[i].size(), td, exp_done(g, t1));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0, g, n_end;
    bit ok;
    beat_t e;
    for (int i = 0; i < 2; i++) begin
      g = gap_of(i);
      clear_mon();
      start[i] = 1'b1; t0 = cyc;
      tick();
      start[i] = 1'b0;
      wait_cyc(t0 + 2 + 20*(g+1));
      // Reset during beat 20, with a write attempt that must not land.
      rst = 1'b1; wr_en = 1'b1; wr_addr = AW'(7); wr_data = ~ref_mem[7];
      #1;
      checks++;
      if ({busy[i], done[i], vld[i], dend[i]} !== 4'b0 || dout[i] !== '0) begin
        errors++;
        $display("FAIL midrst_async dut%0d: got busy=%b done=%b vld=%b end=%b dout=%h, expected all 0",
                 i, busy[i], done[i], vld[i], dend[i], dout[i]);
      end
      tick();
      rst = 1'b0; wr_en = 1'b0;
      repeat (3*(g+1) + 6) tick();
      n_end = 0;
      foreach (bq[i][k]) if (bq[i][k].e) n_end++;
      checks++;
      if (bq[i].size() != 20 || n_end != 0 || dq[i].size() != 0) begin
        errors++;
        $display("FAIL midrst_abort dut%0d: got beats=%0d ends=%0d dones=%0d, expected 20 0 0",
                 i, bq[i].size(), n_end, dq[i].size());
      end
      clear_mon();
      start[i] = 1'b1; t0 = cyc;
      tick();
      start[i] = 1'b0;
      wait_done(i, 1, 400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midrst_done_timeout dut%0d: got %0d done pulses, expected 1", i, dq[i].size()); end
      checks++;
      if (bq[i].size() != TOT) begin errors++; $display("FAIL midrst_count dut%0d: got %0d beats, expected %0d", i, bq[i].size(), TOT); end
      for (int k = 0; k < TOT && k < bq[i].size(); k++) begin
        e = exp_beat(k, g, t0);
        checks++;
        if (bq[i][k] !== e) begin
          errors++;
          $display("FAIL midrst_beat dut%0d k=%0d: got d=%h cyc=%0d end=%b, expected d=%h cyc=%0d end=%b",
                   i, k, bq[i][k].d, bq[i][k].c, bq[i][k].e, e.d, e.c, e.e);
        end
      end
    end
  endtask

  task automatic test_bus_rules();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (idle_bad[i] != 0) begin errors++; $display("FAIL idle_bus dut%0d: got %0d idle cycles with nonzero dout/end, expected 0", i, idle_bad[i]); end
      checks++;
      if (busy_bad[i] != 0) begin errors++; $display("FAIL busy_at_done dut%0d: got %0d done cycles with busy high, expected 0", i, busy_bad[i]); end
    end
    checks++;
    if (consec[1] != 0) begin errors++; $display("FAIL gap_spacing dut1: got %0d consecutive valid cycles, expected 0", consec[1]); end
    checks++;
    if (consec[0] < TOT - 1) begin errors++; $display("FAIL gap0_stream dut0: got %0d consecutive valid cycles, expected at least %0d", consec[0], TOT - 1); end
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_random_frame();
    test_dropped_writes();
    test_back_to_back();
    test_reset_mid_frame();
    test_bus_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
